// File: rtl/game_ctrl.sv
// Game-flow sequencer: turns debounced start/pause/end_game levels into run enable,
// a one-cycle datapath reset pulse, a pre-round countdown and session high-score tracking.
module game_ctrl #(
    parameter int COUNT_SECS = 3,
    parameter int CNT_W      = 2,
    parameter int SCORE_W    = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_btn,
    input  logic               pause_btn,
    input  logic               one_hz_clk,
    input  logic               end_game,
    input  logic [SCORE_W-1:0] score,
    output logic               run,
    output logic               game_rst,
    output logic [2:0]         state,
    output logic [CNT_W-1:0]   countdown,
    output logic [SCORE_W-1:0] high_score,
    output logic               new_high
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COUNTDOWN = 3'd1,
        PLAY      = 3'd2,
        PAUSE     = 3'd3,
        OVER      = 3'd4
    } state_t;

    state_t st;

    logic start_q;
    logic pause_q;
    logic hz_q;
    logic start_rise;
    logic pause_rise;
    logic hz_rise;

    // Delayed copies keep loading during reset so a level held through reset is not an edge.
    always_ff @(posedge clk) begin
        start_q <= start_btn;
        pause_q <= pause_btn;
        hz_q    <= one_hz_clk;
    end

    assign start_rise = start_btn  & ~start_q;
    assign pause_rise = pause_btn  & ~pause_q;
    assign hz_rise    = one_hz_clk & ~hz_q;
    assign state      = st;

    always_ff @(posedge clk) begin
        if (!rst) begin
            st         <= IDLE;
            run        <= 1'b0;
            game_rst   <= 1'b0;
            countdown  <= '0;
            high_score <= '0;
            new_high   <= 1'b0;
        end else begin
            game_rst <= 1'b0;
            case (st)
                IDLE: begin
                    if (start_rise) begin
                        st        <= COUNTDOWN;
                        countdown <= CNT_W'(COUNT_SECS);
                        game_rst  <= 1'b1;
                    end
                end
                COUNTDOWN: begin
                    if (start_rise) begin
                        countdown <= CNT_W'(COUNT_SECS);
                        game_rst  <= 1'b1;
                    end else if (hz_rise) begin
                        if (countdown > CNT_W'(1)) begin
                            countdown <= countdown - CNT_W'(1);
                        end else begin
                            st        <= PLAY;
                            countdown <= '0;
                            run       <= 1'b1;
                        end
                    end
                end
                PLAY: begin
                    // Restart outranks end_game, so a simultaneous finish never scores.
                    if (start_rise) begin
                        st        <= COUNTDOWN;
                        countdown <= CNT_W'(COUNT_SECS);
                        game_rst  <= 1'b1;
                        run       <= 1'b0;
                    end else if (end_game) begin
                        st  <= OVER;
                        run <= 1'b0;
                        if (score > high_score) begin
                            high_score <= score;
                            new_high   <= 1'b1;
                        end else begin
                            new_high <= 1'b0;
                        end
                    end else if (pause_rise) begin
                        st  <= PAUSE;
                        run <= 1'b0;
                    end
                end
                PAUSE: begin
                    if (start_rise) begin
                        st        <= COUNTDOWN;
                        countdown <= CNT_W'(COUNT_SECS);
                        game_rst  <= 1'b1;
                    end else if (pause_rise) begin
                        st  <= PLAY;
                        run <= 1'b1;
                    end
                end
                OVER: begin
                    run <= 1'b0;
                    if (start_rise) begin
                        st        <= COUNTDOWN;
                        countdown <= CNT_W'(COUNT_SECS);
                        game_rst  <= 1'b1;
                        new_high  <= 1'b0;
                    end
                end
                default: begin
                    st        <= IDLE;
                    run       <= 1'b0;
                    countdown <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
- Top-level game-flow sequencer sitting between the debounced button inputs and the gameplay datapath (falling item, stack, score, timer).
- Turns start/pause/end_game into a clean run enable and a one-cycle datapath reset pulse.
- Runs a pre-round countdown, tracks the session high score, and flags a new record at game over.

Parameters:
- COUNT_SECS, 3: countdown length in seconds before play begins (1..2^CNT_W-1).
- CNT_W, 2: width of countdown output.
- SCORE_W, 7: width of score and high_score.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- start_btn  in  1  debounced start level; acted on at its rising edge.
- pause_btn  in  1  debounced pause level; acted on at its rising edge.
- one_hz_clk  in  1  divided 1 Hz square wave; sampled in clk domain, acted on at its rising edge.
- end_game  in  1  timer-expired level from round counter.
- score  in  SCORE_W  current registered score.
- run  out  1  1 only in PLAY; drives datapath pause (datapath stop = ~run).
- game_rst  out  1  one-cycle pulse that clears datapath, score and timer.
- state  out  3  IDLE=0, COUNTDOWN=1, PLAY=2, PAUSE=3, OVER=4.
- countdown  out  CNT_W  seconds remaining in COUNTDOWN, else 0.
- high_score  out  SCORE_W  best score this power-on session.
- new_high  out  1  1 in OVER when the finished game set a new record.

Behaviour:
- Edge detect: start_btn, pause_btn and one_hz_clk each have a registered copy (_q). rise = in & ~in_q. While rst=0, each _q loads its current input, so a button held through reset gives no edge.
- Reset (rst=0 at clk edge): state=IDLE, run=0, game_rst=0, countdown=0, high_score=0, new_high=0.
- All outputs are registered. Actions take effect at the first clk edge that samples the rising input; outputs reflect the change one cycle later.
- Event priority within a cycle: start rise > end_game > pause rise > one_hz rise.
- IDLE:
  - start rise -> COUNTDOWN; countdown=COUNT_SECS; game_rst=1 for exactly one cycle.
  - Other events ignored.
- COUNTDOWN:
  - one_hz rise with countdown>1 -> countdown-1.
  - one_hz rise with countdown==1 -> PLAY; countdown=0; run=1.
  - start rise restarts: countdown=COUNT_SECS, game_rst pulse.
  - pause and end_game ignored.
- PLAY:
  - end_game=1 -> OVER; run=0. If score > high_score: high_score<=score and new_high=1, both in the same edge. Otherwise new_high=0. Equal score is not a record.
  - pause rise -> PAUSE; run=0.
  - start rise -> COUNTDOWN with game_rst pulse (restart).
- PAUSE:
  - pause rise -> PLAY; run=1.
  - start rise -> restart, as above.
  - end_game ignored (timer is frozen).
- OVER:
  - run=0; high_score and new_high hold.
  - start rise -> COUNTDOWN; game_rst pulse; new_high=0.
  - pause ignored.
- Start and end_game in the same cycle in PLAY: restart wins; no high-score update.
- game_rst is never asserted for more than one consecutive cycle, even if start_btn is held.
- Illegal state encodings (5-7) recover to IDLE on the next edge with run=0.
- Reset mid-game: returns to IDLE and clears high_score.

Test Plan:
- Reset with start_btn held high, release rst -> no game_rst pulse; state stays 0. Drop start, raise start -> game_rst high 1 cycle; state=1; countdown=3.
- From COUNTDOWN apply 3 one_hz rising edges -> countdown 3→2→1, then state=2, run=1, countdown=0. pause pulses during countdown -> no effect.
- In PLAY pulse pause -> state=3, run=0. Assert end_game -> stays 3. Pulse pause -> state=2, run=1.
- In PLAY with high_score=0, score=42, assert end_game -> state=4, high_score=42, new_high=1. New game with score=42 at end -> high_score=42, new_high=0. Next game with score=50 -> high_score=50, new_high=1.
- In PLAY, raise start_btn and end_game in the same cycle -> state=1, game_rst pulse, high_score unchanged.
- In OVER, pulse start -> new_high=0, state=1, game_rst pulse. Assert rst=0 mid-PLAY -> next cycle state=0, run=0, high_score=0.
